// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe -- four-stage pre-add / multiply / post-add MAC pipeline.
//
// Datapath per beat:
//   pre    = D + B   or  D - B               (PRE_W bits, wraps)
//   M      = A * pre                         (A_W+PRE_W bits)
//   X      = C  or  current P (accumulate)
//   result = X + M   or  X - M               (P_W+1 bits; top bit is ovf)
//
// Stages:
//   S1: register operands, opmode, in_valid
//   S2: second A register, pre-adder result
//   S3: product
//   S4: P, ovf, out_valid
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ce           clock enable; every register, valid bits included, holds while low
//   in_valid     operand beat valid
//   A,B,D,C      unsigned operands
//   opmode[0]    pre-subtract (D - B)
//   opmode[1]    post-subtract (X - M)
//   opmode[2]    accumulate (X = P instead of C)
//   out_valid    P/ovf hold a new result this cycle
//   P            registered result
//   ovf          carry/borrow of the post-adder for the current result
//
// Handshake: there is no backpressure. A beat is accepted on every enabled
// edge where in_valid=1; out_valid is high for exactly one enabled cycle per
// accepted beat, four enabled edges later. While ce=0 everything, including
// out_valid, is frozen.
//
// Build option: define DSP_MAC_PIPE_SAT_EN to saturate P on carry (all ones)
// or borrow (zero). Without it P wraps modulo 2^P_W. ovf is set either way.

module dsp_mac_pipe #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int D_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           in_valid,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [D_W-1:0] D,
    input  logic [C_W-1:0] C,
    input  logic [2:0]     opmode,
    output logic           out_valid,
    output logic [P_W-1:0] P,
    output logic           ovf
);

    localparam int PRE_W = ((D_W > B_W) ? D_W : B_W) + 1;
    localparam int M_W   = A_W + PRE_W;

    // ---------------- S1 ----------------
    logic [A_W-1:0] a1_q, a1_d;
    logic [B_W-1:0] b1_q, b1_d;
    logic [D_W-1:0] d1_q, d1_d;
    logic [C_W-1:0] c1_q, c1_d;
    logic [2:0]     op1_q, op1_d;
    logic           v1_q, v1_d;

    // ---------------- S2 ----------------
    // Only the post-adder controls {accumulate, subtract} travel past S2.
    logic [A_W-1:0]   a2_q, a2_d;
    logic [PRE_W-1:0] pre2_q, pre2_d;
    logic [C_W-1:0]   c2_q, c2_d;
    logic [1:0]       op2_q, op2_d;
    logic             v2_q, v2_d;

    // ---------------- S3 ----------------
    logic [M_W-1:0] m3_q, m3_d;
    logic [C_W-1:0] c3_q, c3_d;
    logic [1:0]     op3_q, op3_d;
    logic           v3_q, v3_d;

    // ---------------- S4 ----------------
    logic [P_W-1:0] p_q, p_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;

    // Post-adder intermediates
    logic [P_W-1:0] x_sel;
    logic [P_W-1:0] m_ext;
    logic [P_W:0]   sum_full;

    always_comb begin
        // S1
        a1_d  = A;
        b1_d  = B;
        d1_d  = D;
        c1_d  = C;
        op1_d = opmode;
        v1_d  = in_valid;

        // S2
        a2_d   = a1_q;
        pre2_d = op1_q[0] ? (PRE_W'(d1_q) - PRE_W'(b1_q))
                          : (PRE_W'(d1_q) + PRE_W'(b1_q));
        c2_d   = c1_q;
        op2_d  = op1_q[2:1];
        v2_d   = v1_q;

        // S3
        m3_d  = M_W'(a2_q) * M_W'(pre2_q);
        c3_d  = c2_q;
        op3_d = op2_q;
        v3_d  = v2_q;

        // S4: accumulate reads P directly, so back-to-back accumulate beats
        // each see the result of the previous valid beat.
        x_sel    = op3_q[1] ? p_q : P_W'(c3_q);
        m_ext    = P_W'(m3_q);
        sum_full = op3_q[0] ? ({1'b0, x_sel} - {1'b0, m_ext})
                            : ({1'b0, x_sel} + {1'b0, m_ext});

        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = v3_q;
        if (v3_q) begin
            ovf_d = sum_full[P_W];
`ifdef DSP_MAC_PIPE_SAT_EN
            if (sum_full[P_W]) begin
                // Borrow clamps to zero, carry clamps to full scale.
                p_d = op3_q[0] ? '0 : '1;
            end else begin
                p_d = sum_full[P_W-1:0];
            end
`else
            p_d = sum_full[P_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q        <= '0;
            b1_q        <= '0;
            d1_q        <= '0;
            c1_q        <= '0;
            op1_q       <= '0;
            v1_q        <= 1'b0;
            a2_q        <= '0;
            pre2_q      <= '0;
            c2_q        <= '0;
            op2_q       <= '0;
            v2_q        <= 1'b0;
            m3_q        <= '0;
            c3_q        <= '0;
            op3_q       <= '0;
            v3_q        <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            d1_q        <= d1_d;
            c1_q        <= c1_d;
            op1_q       <= op1_d;
            v1_q        <= v1_d;
            a2_q        <= a2_d;
            pre2_q      <= pre2_d;
            c2_q        <= c2_d;
            op2_q       <= op2_d;
            v2_q        <= v2_d;
            m3_q        <= m3_d;
            c3_q        <= c3_d;
            op3_q       <= op3_d;
            v3_q        <= v3_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter A_W, default 18: width of multiplicand A.
REQ-002 SHALL have parameter B_W, default 18: width of pre-adder operand B.
REQ-003 SHALL have parameter D_W, default 18: width of pre-adder operand D.
REQ-004 SHALL have parameter C_W, default 48: width of post-adder operand C.
REQ-005 SHALL have parameter P_W, default 48: result width; P_W >= A_W+PRE_W and P_W >= C_W, where PRE_W = max(D_W,B_W)+1.
REQ-006 SHALL have port clk, input, 1: single clock; all registers on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port ce, input, 1: clock enable for every register.
REQ-009 SHALL have port in_valid, input, 1: operand beat valid.
REQ-010 SHALL have ports A, B, D, C, inputs, A_W/B_W/D_W/C_W: unsigned operands.
REQ-011 SHALL have port opmode, input, 3: bit0 pre-sub (D-B), bit1 post-sub, bit2 accumulate.
REQ-012 SHALL have port out_valid, output, 1: P holds a new result this cycle.
REQ-013 SHALL have port P, output, P_W: registered result.
REQ-014 SHALL have port ovf, output, 1: carry/borrow of the post-adder for the current result.

Function
REQ-015 SHALL be a 4-stage pipeline: S1 registers A,B,D,C,opmode,in_valid; S2 registers A (second stage) and pre-adder; S3 registers product; S4 registers P, ovf, out_valid.
REQ-016 SHALL assert out_valid exactly 4 enabled (ce=1) cycles after the in_valid beat, with P/ovf of that beat.
REQ-017 SHALL compute pre = D+B (opmode[0]=0) or D-B (=1), PRE_W bits, modulo 2^PRE_W.
REQ-018 SHALL compute M = A*pre, A_W+PRE_W bits, zero-extended to P_W.
REQ-019 SHALL select X = C zero-extended (opmode[2]=0) or current P (opmode[2]=1).
REQ-020 SHALL compute result = X+M (opmode[1]=0) or X-M (=1) in P_W+1 bits; P = low P_W bits, ovf = bit P_W.
REQ-021 SHALL carry opmode through the pipeline with its beat; opmode changes never affect beats already in flight.
REQ-022 SHALL update P and ovf only when the S3 beat is valid; bubbles hold P and ovf and drive out_valid=0.
REQ-023 SHALL support back-to-back accumulate beats, each seeing the P produced by the previous valid beat (single-cycle feedback).
REQ-024 SHALL treat an accumulate beat with no earlier result since reset as accumulating onto P=0; an opmode[2]=0 beat restarts accumulation from C.
REQ-025 SHALL freeze all registers, including valid bits, P and out_valid, while ce=0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all pipeline registers, P=0, ovf=0, out_valid=0.
REQ-027 SHALL discard in-flight beats on reset; no result from them appears after release.

Configuration
REQ-028 SHALL honour macro DSP_MAC_PIPE_SAT_EN: if defined, P = all-ones on carry and 0 on borrow, with ovf=1; if undefined, P wraps modulo 2^P_W, with ovf=1.

Verification
REQ-029 Defaults, opmode=000, A=3 B=4 D=5 C=10 -> 4 cycles later out_valid=1, P=37, ovf=0.
REQ-030 opmode=001, A=1 B=7 D=5 C=0 -> P=524286 (pre wraps in 19 bits), ovf=0.
REQ-031 Beat A=2 B=1 D=1 C=0 opmode=000, then 3 consecutive beats with opmode=100 -> P=4,8,12,16 on 4 consecutive cycles.
REQ-032 opmode=010, A=1 B=0 D=1 C=0 -> ovf=1; P=2^48-1 without SAT_EN, P=0 with SAT_EN.
REQ-033 Stream of 4 beats with ce=0 for 3 cycles mid-stream -> same P sequence, each out_valid delayed 3 cycles.
REQ-034 rst_n low 1 cycle with 3 beats in flight -> P=0, out_valid=0 immediately; no out_valid until a new beat plus 4 cycles.
